rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter and scoreboard for the 32x32 register file. Three write-back sources (ALU, load unit, multi-cycle mul/div unit) share the register file's single write port. The block grants one source per cycle with round-robin fairness and drives the register file write port from a registered stage. It also keeps a per-register busy scoreboard that the decode stage uses for hazard stalls.

## Interface
Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 registers)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- src_valid  in  3  per-source write request; bit 0 = ALU, 1 = load, 2 = mul/div
- src_ready  out  3  per-source grant, combinational, one-hot or zero
- src_addr  in  3*ADDR_W  destination register, source i at bits [i*ADDR_W +: ADDR_W]
- src_data  in  3*DATA_W  write data, source i at bits [i*DATA_W +: DATA_W]
- rf_reg_write  out  1  register file write enable (registered)
- rf_write_addr  out  ADDR_W  register file write address (registered)
- rf_write_data  out  DATA_W  register file write data (registered)
- iss_valid  in  1  decode issues an instruction that will write iss_rd
- iss_rd  in  ADDR_W  destination of the issued instruction
- rd_addr_1, rd_addr_2  in  ADDR_W each  source-operand query addresses
- busy_1, busy_2  out  1 each  combinational scoreboard lookup for rd_addr_1 / rd_addr_2
- waw_err  out  1  sticky error: issue to an already-busy register
- idle  out  1  no busy bits set, no src_valid asserted, rf_reg_write low

## Operation
- Handshake: a source raises src_valid with stable addr/data and holds them until src_ready is high in the same cycle. A transfer occurs on the edge where valid && ready.
- Arbitration: round-robin over the 3 sources. rr_ptr holds the last granted index. Search order is rr_ptr+1, rr_ptr+2, rr_ptr (mod 3). At most one src_ready bit is high, and only for a valid source. rr_ptr updates to the granted index on a transfer and is unchanged with no transfer.
- Output stage: on a transfer, rf_write_addr/rf_write_data load from the granted source. rf_reg_write <= (addr != 0). With no transfer, rf_reg_write <= 0 and addr/data hold their values. The register file accepts every cycle, so there is no backpressure from it.
- Address 0 writes complete the handshake normally but never assert rf_reg_write.
- Scoreboard: 32 busy bits; bit 0 is constant 0.
  - Set: iss_valid && iss_rd != 0 sets busy[iss_rd] at the edge.
  - Clear: busy[rf_write_addr] clears on the edge where rf_reg_write is high, which is the same edge the register file stores the data.
  - Same register set and cleared on one edge: set wins (new producer).
- busy_x = busy[rd_addr_x]. This is a pure lookup with no bypass from the output stage.
- waw_err: sets when iss_valid, iss_rd != 0, and busy[iss_rd] is already 1 and not being cleared that edge. It stays set until reset.

## Timing
- Reset values:
  - src_ready = 0 (combinational, follows valid)
  - rf_reg_write = 0, rf_write_addr = 0, rf_write_data = 0
  - all busy bits = 0, waw_err = 0
  - rr_ptr = 2, so source 0 has first priority after reset
- Latency: transfer at edge N gives rf_reg_write high during cycle N+1. The register file is written at edge N+1. busy clears at edge N+1, so busy_x reads 0 from cycle N+2.
- Throughput: one write per cycle sustained. Three sources continuously valid are granted in order 0,1,2,0,1,2...
- Asserting reset mid-operation drops any pending output-stage write, clears all busy bits and returns rr_ptr to 2. An unaccepted source request is simply re-arbitrated after reset.

## Test plan
- Reset, then all three src_valid held high with addrs 1,2,3 -> src_ready = 001, 010, 100, 001 on consecutive cycles. rf_write_addr = 1,2,3,1 one cycle later, rf_reg_write high each cycle.
- iss_valid with iss_rd=5, then source 1 writes addr 5 data 0xDEADBEEF -> busy for r5 reads 1 from the cycle after issue. rf_reg_write is high for one cycle with addr 5 and data 0xDEADBEEF. Busy for r5 reads 0 two cycles after the transfer.
- Source 0 writes addr 0 data 0x12345678 -> src_ready high, rf_reg_write stays 0, busy_1 with rd_addr_1=0 reads 0 throughout.
- busy[7] set and the write to r7 is committing (rf_reg_write=1, addr 7) while iss_valid issues iss_rd=7 on the same edge -> busy[7] remains 1 and waw_err stays 0. A second issue to r7 on the following cycle sets waw_err.
- Only source 2 valid for 4 cycles, then sources 0 and 2 both valid -> source 0 granted first (rr_ptr=2). Assert reset during a transfer cycle -> rf_reg_write 0 and busy all 0 immediately, and the source 0 grant order restarts after reset deasserts.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, with a
// per-register busy scoreboard that decode uses for hazard stalls.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            src_valid,
  output logic [2:0]            src_ready,
  input  logic [3*ADDR_W-1:0]   src_addr,
  input  logic [3*DATA_W-1:0]   src_data,
  output logic                  rf_reg_write,
  output logic [ADDR_W-1:0]     rf_write_addr,
  output logic [DATA_W-1:0]     rf_write_data,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_rd,
  input  logic [ADDR_W-1:0]     rd_addr_1,
  input  logic [ADDR_W-1:0]     rd_addr_2,
  output logic                  busy_1,
  output logic                  busy_2,
  output logic                  waw_err,
  output logic                  idle
);
  localparam int NREG = 1 << ADDR_W;

  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0]        cand [3];
  logic [1:0]        gnt_idx;
  logic              fire;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [NREG-1:0]   busy_q, busy_d, clr_vec, set_vec;
  logic              waw_q, waw_d;

  // Search order rr+1, rr+2, rr (mod 3); the last grantee goes last.
  always_comb begin
    cand[0]   = (rr_ptr_q == 2'd2) ? 2'd0 : rr_ptr_q + 2'd1;
    cand[1]   = (cand[0] == 2'd2) ? 2'd0 : cand[0] + 2'd1;
    cand[2]   = rr_ptr_q;
    src_ready = '0;
    gnt_idx   = rr_ptr_q;
    fire      = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!fire && src_valid[cand[k]]) begin
        fire    = 1'b1;
        gnt_idx = cand[k];
      end
    end
    if (fire) src_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    we_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    if (fire) begin
      rr_ptr_d = gnt_idx;
      wa_d     = src_addr[gnt_idx*ADDR_W +: ADDR_W];
      wd_d     = src_data[gnt_idx*DATA_W +: DATA_W];
      we_d     = (wa_d != '0);
    end
  end

  // Clear tracks the cycle the register file actually stores; a same-edge
  // issue to that register is a new producer, so set overrides clear.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (we_q) clr_vec[wa_q] = 1'b1;
    if (iss_valid && iss_rd != '0) set_vec[iss_rd] = 1'b1;
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
    waw_d     = waw_q | (iss_valid && iss_rd != '0 && busy_q[iss_rd] && !clr_vec[iss_rd]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= 2'd2;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      busy_q   <= '0;
      waw_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      busy_q   <= busy_d;
      waw_q    <= waw_d;
    end
  end

  assign rf_reg_write  = we_q;
  assign rf_write_addr = wa_q;
  assign rf_write_data = wd_q;
  assign busy_1        = busy_q[rd_addr_1];
  assign busy_2        = busy_q[rd_addr_2];
  assign waw_err       = waw_q;
  assign idle          = ~|busy_q && ~|src_valid && !we_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed vector bench for rf_wb_arbiter: one table row per clock cycle,
// plus a hand-written async reset sequence.
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [14:0] src_addr;
  logic [95:0] src_data;
  logic        rf_reg_write;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        iss_valid;
  logic [4:0]  iss_rd, rd_addr_1, rd_addr_2;
  logic        busy_1, busy_2, waw_err, idle;

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(src_addr), .src_data(src_data),
    .rf_reg_write(rf_reg_write), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .busy_1(busy_1), .busy_2(busy_2),
    .waw_err(waw_err), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sv;
    logic [4:0]  a0, a1, a2;
    logic        iv;
    logic [4:0]  ird, r1, r2;
    logic [2:0]  rdy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        b1, b2, waw, idl;
  } vec_t;

  vec_t tv [26];

  function automatic vec_t mk(logic [2:0] sv, logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                              logic iv, logic [4:0] ird, logic [4:0] r1, logic [4:0] r2,
                              logic [2:0] rdy, logic we, logic [4:0] wa, logic [31:0] wd,
                              logic b1, logic b2, logic waw, logic idl);
    vec_t v;
    v.sv = sv; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.iv = iv; v.ird = ird;
    v.r1 = r1; v.r2 = r2; v.rdy = rdy; v.we = we; v.wa = wa; v.wd = wd;
    v.b1 = b1; v.b2 = b2; v.waw = waw; v.idl = idl;
    return v;
  endfunction

  // Each source's data encodes its index and address, so a wrong mux shows.
  function automatic logic [31:0] dat(int s, logic [4:0] a);
    return 32'hA000_0000 + 32'(s * 256) + 32'(a);
  endfunction

  task automatic drive(logic [2:0] sv, logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                       logic iv, logic [4:0] ird, logic [4:0] r1, logic [4:0] r2);
    src_valid = sv;
    src_addr  = {a2, a1, a0};
    src_data  = {dat(2, a2), dat(1, a1), dat(0, a0)};
    iss_valid = iv; iss_rd = ird; rd_addr_1 = r1; rd_addr_2 = r2;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    tv[0]  = mk(3'b111, 1, 2, 3, 0, 0, 1, 2,   3'b001, 0, 0, 32'h0,         0, 0, 0, 0);
    tv[1]  = mk(3'b111, 1, 2, 3, 0, 0, 1, 2,   3'b010, 1, 1, 32'hA000_0001, 0, 0, 0, 0);
    tv[2]  = mk(3'b111, 1, 2, 3, 0, 0, 1, 2,   3'b100, 1, 2, 32'hA000_0102, 0, 0, 0, 0);
    tv[3]  = mk(3'b111, 1, 2, 3, 0, 0, 1, 2,   3'b001, 1, 3, 32'hA000_0203, 0, 0, 0, 0);
    tv[4]  = mk(3'b000, 1, 2, 3, 0, 0, 1, 2,   3'b000, 1, 1, 32'hA000_0001, 0, 0, 0, 0);
    tv[5]  = mk(3'b000, 1, 2, 3, 0, 0, 1, 2,   3'b000, 0, 1, 32'hA000_0001, 0, 0, 0, 1);
    tv[6]  = mk(3'b000, 0, 0, 0, 1, 5, 5, 5,   3'b000, 0, 1, 32'hA000_0001, 0, 0, 0, 1);
    tv[7]  = mk(3'b010, 0, 5, 0, 0, 0, 5, 5,   3'b010, 0, 1, 32'hA000_0001, 1, 1, 0, 0);
    tv[8]  = mk(3'b000, 0, 5, 0, 0, 0, 5, 5,   3'b000, 1, 5, 32'hA000_0105, 1, 1, 0, 0);
    tv[9]  = mk(3'b000, 0, 5, 0, 0, 0, 5, 5,   3'b000, 0, 5, 32'hA000_0105, 0, 0, 0, 1);
    tv[10] = mk(3'b001, 0, 0, 0, 0, 0, 0, 5,   3'b001, 0, 5, 32'hA000_0105, 0, 0, 0, 0);
    tv[11] = mk(3'b000, 0, 0, 0, 0, 0, 0, 5,   3'b000, 0, 0, 32'hA000_0000, 0, 0, 0, 1);
    tv[12] = mk(3'b000, 0, 0, 0, 1, 7, 7, 0,   3'b000, 0, 0, 32'hA000_0000, 0, 0, 0, 1);
    tv[13] = mk(3'b100, 0, 0, 7, 0, 0, 7, 0,   3'b100, 0, 0, 32'hA000_0000, 1, 0, 0, 0);
    tv[14] = mk(3'b000, 0, 0, 7, 1, 7, 7, 0,   3'b000, 1, 7, 32'hA000_0207, 1, 0, 0, 0);
    tv[15] = mk(3'b000, 0, 0, 7, 1, 7, 7, 0,   3'b000, 0, 7, 32'hA000_0207, 1, 0, 0, 0);
    tv[16] = mk(3'b001, 7, 0, 0, 0, 0, 7, 0,   3'b001, 0, 7, 32'hA000_0207, 1, 0, 1, 0);
    tv[17] = mk(3'b000, 7, 0, 0, 0, 0, 7, 0,   3'b000, 1, 7, 32'hA000_0007, 1, 0, 1, 0);
    tv[18] = mk(3'b000, 7, 0, 0, 0, 0, 7, 0,   3'b000, 0, 7, 32'hA000_0007, 0, 0, 1, 1);
    tv[19] = mk(3'b100, 0, 0, 9, 0, 0, 9, 10,  3'b100, 0, 7, 32'hA000_0007, 0, 0, 1, 0);
    tv[20] = mk(3'b100, 0, 0, 9, 0, 0, 9, 10,  3'b100, 1, 9, 32'hA000_0209, 0, 0, 1, 0);
    tv[21] = mk(3'b100, 0, 0, 9, 0, 0, 9, 10,  3'b100, 1, 9, 32'hA000_0209, 0, 0, 1, 0);
    tv[22] = mk(3'b100, 0, 0, 9, 0, 0, 9, 10,  3'b100, 1, 9, 32'hA000_0209, 0, 0, 1, 0);
    tv[23] = mk(3'b101, 10, 0, 9, 0, 0, 9, 10, 3'b001, 1, 9, 32'hA000_0209, 0, 0, 1, 0);
    tv[24] = mk(3'b101, 10, 0, 9, 0, 0, 9, 10, 3'b100, 1, 10, 32'hA000_000A, 0, 0, 1, 0);
    tv[25] = mk(3'b101, 10, 0, 9, 0, 0, 9, 10, 3'b001, 1, 9, 32'hA000_0209, 0, 0, 1, 0);

    reset = 1'b1;
    drive(3'b000, 0, 0, 0, 0, 0, 1, 2);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'(src_ready), 0);
    chk("rst_we",    32'(rf_reg_write), 0);
    chk("rst_wa",    32'(rf_write_addr), 0);
    chk("rst_wd",    rf_write_data, 0);
    chk("rst_waw",   32'(waw_err), 0);
    chk("rst_idle",  32'(idle), 1);

    for (int i = 0; i < 26; i++) begin
      @(posedge clk); #1;
      drive(tv[i].sv, tv[i].a0, tv[i].a1, tv[i].a2, tv[i].iv, tv[i].ird, tv[i].r1, tv[i].r2);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(src_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d_we", i),    32'(rf_reg_write), 32'(tv[i].we));
      chk($sformatf("v%0d_wa", i),    32'(rf_write_addr), 32'(tv[i].wa));
      chk($sformatf("v%0d_wd", i),    rf_write_data, tv[i].wd);
      chk($sformatf("v%0d_busy1", i), 32'(busy_1), 32'(tv[i].b1));
      chk($sformatf("v%0d_busy2", i), 32'(busy_2), 32'(tv[i].b2));
      chk($sformatf("v%0d_waw", i),   32'(waw_err), 32'(tv[i].waw));
      chk($sformatf("v%0d_idle", i),  32'(idle), 32'(tv[i].idl));
    end

    // Async reset while the output stage holds a committing write.
    @(posedge clk); #1;
    drive(3'b011, 4, 6, 0, 1, 12, 12, 0);
    @(negedge clk);
    chk("pre_ready", 32'(src_ready), 32'(3'b010));
    @(posedge clk); #1;
    chk("pre_we",    32'(rf_reg_write), 1);
    chk("pre_busy",  32'(busy_1), 1);
    iss_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_we",    32'(rf_reg_write), 0);
    chk("mid_wa",    32'(rf_write_addr), 0);
    chk("mid_busy",  32'(busy_1), 0);
    chk("mid_waw",   32'(waw_err), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_ready0", 32'(src_ready), 32'(3'b001));
    @(negedge clk);
    chk("post_ready1", 32'(src_ready), 32'(3'b010));
    chk("post_we",     32'(rf_reg_write), 1);
    chk("post_wa",     32'(rf_write_addr), 4);
    chk("post_wd",     rf_write_data, 32'hA000_0004);
    @(posedge clk); #1;
    drive(3'b000, 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
